// File: rtl/watch_adjust_cu_if.sv
// rtl/watch_adjust_cu_if.sv - button/select inputs and tick/busy outputs of watch_adjust_cu
//
// Purpose: bundles the button, field-select and tick signals between the
// button front end (master) and the time-adjust control unit (slave).
// Signals:
//   btn_up, btn_down  debounced buttons, synchronous to clk
//   sel               field-select switches, lowest set bit wins
//   tick_up           one-cycle increment pulse per field
//   tick_down         one-cycle decrement pulse per field
//   busy              a button hold is being tracked
interface watch_adjust_cu_if #(
  parameter int N_FIELD = 3
);
  logic               btn_up;
  logic               btn_down;
  logic [N_FIELD-1:0] sel;
  logic [N_FIELD-1:0] tick_up;
  logic [N_FIELD-1:0] tick_down;
  logic               busy;

  modport master (
    output btn_up, btn_down, sel,
    input  tick_up, tick_down, busy
  );

  modport slave (
    input  btn_up, btn_down, sel,
    output tick_up, tick_down, busy
  );
endinterface

// File: rtl/watch_adjust_cu.sv
// rtl/watch_adjust_cu.sv - time-adjust control unit turning buttons into field ticks
//
// Purpose: converts two debounced up/down buttons into single-cycle
// increment/decrement ticks for the field chosen by the lowest set bit of
// sel. Holding a button auto-repeats after REPEAT_DELAY cycles, then every
// REPEAT_RATE cycles.
// Optional feature macro: WATCH_AUTO_REPEAT_EN. When undefined, each valid
// press gives exactly one tick and the hold is then ignored until both
// buttons are low.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   watch_adjust_cu_if.slave: btn_up, btn_down, sel in;
//         tick_up, tick_down, busy out
module watch_adjust_cu #(
  parameter int N_FIELD      = 3,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  watch_adjust_cu_if.slave bus
);

  localparam int FW = (N_FIELD > 1) ? $clog2(N_FIELD) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               prev_up, prev_down;
  logic               edge_up, edge_down;
  logic               sel_valid;
  logic [FW-1:0]      sel_idx;
  logic [FW-1:0]      field_q;
  logic               dir_up_q;
  logic               latch;
  logic               pend, pend_n;
  logic [N_FIELD-1:0] field_hot;
  logic [N_FIELD-1:0] tick_up_q, tick_down_q;
  logic               busy_q;

`ifdef WATCH_AUTO_REPEAT_EN
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic          held, other;
`endif

  assign edge_up   = bus.btn_up & ~prev_up;
  assign edge_down = bus.btn_down & ~prev_down;

  // Lowest set bit of sel; scanning downwards lets the lowest index win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = N_FIELD - 1; i >= 0; i--) begin
      if (bus.sel[i]) begin
        sel_valid = 1'b1;
        sel_idx   = FW'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = 1'b0;
    latch   = 1'b0;
`ifdef WATCH_AUTO_REPEAT_EN
    cnt_n   = cnt;
    held    = dir_up_q ? bus.btn_up : bus.btn_down;
    other   = dir_up_q ? bus.btn_down : bus.btn_up;
`endif
    case (state)
      S_IDLE: begin
        if (edge_up && edge_down) begin
          state_n = S_LOCK;
        end else if (edge_up || edge_down) begin
          if (!sel_valid) begin
            state_n = S_LOCK;
          end else begin
            pend_n = 1'b1;
            latch  = 1'b1;
`ifdef WATCH_AUTO_REPEAT_EN
            cnt_n   = DELAY_LOAD;
            state_n = S_DELAY;
`else
            state_n = S_LOCK;
`endif
          end
        end
      end
`ifdef WATCH_AUTO_REPEAT_EN
      S_DELAY, S_REPEAT: begin
        if (!held) begin
          state_n = S_IDLE;
        end else if (other) begin
          state_n = S_LOCK;
        end else if (!sel_valid || (sel_idx != field_q)) begin
          state_n = S_LOCK;
        end else if (cnt == '0) begin
          // Counter only reloads on a tick, so it never wraps.
          pend_n  = 1'b1;
          cnt_n   = RATE_LOAD;
          state_n = S_REPEAT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      S_LOCK: begin
        if (!bus.btn_up && !bus.btn_down) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign field_hot = N_FIELD'(1) << field_q;

  // The decision is registered in pend and then turned into the tick on the
  // following edge, giving one cycle between sampled press and tick output.
  // Reset enters LOCK so a button still held across reset is not taken as
  // a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOCK;
      prev_up     <= 1'b0;
      prev_down   <= 1'b0;
      pend        <= 1'b0;
      field_q     <= '0;
      dir_up_q    <= 1'b0;
      tick_up_q   <= '0;
      tick_down_q <= '0;
      busy_q      <= 1'b0;
`ifdef WATCH_AUTO_REPEAT_EN
      cnt         <= '0;
`endif
    end else begin
      state     <= state_n;
      prev_up   <= bus.btn_up;
      prev_down <= bus.btn_down;
      pend      <= pend_n;
      if (latch) begin
        field_q  <= sel_idx;
        dir_up_q <= edge_up;
      end
      tick_up_q   <= (pend && dir_up_q) ? field_hot : '0;
      tick_down_q <= (pend && !dir_up_q) ? field_hot : '0;
      busy_q      <= (state_n != S_IDLE);
`ifdef WATCH_AUTO_REPEAT_EN
      cnt <= cnt_n;
`endif
    end
  end

  assign bus.tick_up   = tick_up_q;
  assign bus.tick_down = tick_down_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_watch_adjust_cu.sv
// tb/tb_watch_adjust_cu.sv - directed self-checking bench for watch_adjust_cu
module tb_watch_adjust_cu;
  localparam int NF = 3;
  localparam int RD = 8;
  localparam int RR = 4;
`ifdef WATCH_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    int       cyc;
    logic [2:0] up;
    logic [2:0] dn;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  log_q[$];

  always #5 clk = ~clk;

  watch_adjust_cu_if #(.N_FIELD(NF)) bus ();

  watch_adjust_cu #(
    .N_FIELD(NF),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (!rst && ((bus.tick_up | bus.tick_down) != 3'b000)) begin
      e.cyc = cyc;
      e.up  = bus.tick_up;
      e.dn  = bus.tick_down;
      log_q.push_back(e);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(6);
    log_q.delete();
  endtask

  task automatic test_reset();
    int k;
    rst          = 1'b1;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    bus.sel      = 3'b010;
    step(3);
    @(negedge clk);
    n_tests++;
    if (bus.tick_up !== 3'b000) begin
      n_fail++; $display("FAIL reset_tick_up: got %b expected 000", bus.tick_up);
    end
    n_tests++;
    if (bus.tick_down !== 3'b000) begin
      n_fail++; $display("FAIL reset_tick_down: got %b expected 000", bus.tick_down);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    bus.btn_down = 1'b0;
    step(1);
    rst = 1'b0;
    log_q.delete();
    step(12);
    n_tests++;
    if (log_q.size() != 0) begin
      n_fail++; $display("FAIL reset_held_no_tick: got %0d ticks expected 0", log_q.size());
    end
    bus.btn_up = 1'b0;
    step(3);
    log_q.delete();
    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(4);
    bus.btn_up = 1'b0;
    step(4);
    n_tests++;
    if (log_q.size() != 1) begin
      n_fail++; $display("FAIL reset_repress_count: got %0d expected 1", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0].cyc - k != 1) begin
        n_fail++; $display("FAIL reset_repress_cycle: got %0d expected 1", log_q[0].cyc - k);
      end
      n_tests++;
      if (log_q[0].up !== 3'b010) begin
        n_fail++; $display("FAIL reset_repress_field: got %b expected 010", log_q[0].up);
      end
    end
    // asynchronous reset while a tick is on the outputs
    bus.btn_up = 1'b0;
    step(4);
    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(2);
    n_tests++;
    if (bus.tick_up !== 3'b010) begin
      n_fail++; $display("FAIL async_pre_tick: got %b expected 010", bus.tick_up);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.tick_up !== 3'b000) begin
      n_fail++; $display("FAIL async_tick_clear: got %b expected 000", bus.tick_up);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL async_busy_clear: got %b expected 0", bus.busy);
    end
    bus.btn_up = 1'b0;
    step(2);
    rst = 1'b0;
    idle_all();
  endtask

  task automatic test_single_press();
    int k;
    bus.sel = 3'b010;
    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(2);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_high: got %b expected 1", bus.busy);
    end
    step(1);
    bus.btn_up = 1'b0;
    step(3);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_low: got %b expected 0", bus.busy);
    end
    step(8);
    n_tests++;
    if (log_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0].cyc - k != 1) begin
        n_fail++; $display("FAIL single_cycle: got %0d expected 1", log_q[0].cyc - k);
      end
      n_tests++;
      if (log_q[0].up !== 3'b010 || log_q[0].dn !== 3'b000) begin
        n_fail++; $display("FAIL single_value: got up=%b dn=%b expected up=010 dn=000",
                           log_q[0].up, log_q[0].dn);
      end
    end
    idle_all();
  endtask

  task automatic test_auto_repeat();
    int k;
    int exp_c[$];
    if (AR) exp_c = '{1, 9, 13, 17, 21, 25, 29};
    else    exp_c = '{1};
    bus.sel = 3'b100;
    k = cyc + 1;
    bus.btn_down = 1'b1;
    step(30);
    bus.btn_down = 1'b0;
    step(10);
    n_tests++;
    if (log_q.size() != exp_c.size()) begin
      n_fail++; $display("FAIL repeat_count: got %0d expected %0d", log_q.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < log_q.size(); i++) begin
      n_tests++;
      if (log_q[i].cyc - k != exp_c[i]) begin
        n_fail++; $display("FAIL repeat_cycle[%0d]: got %0d expected %0d", i, log_q[i].cyc - k, exp_c[i]);
      end
      n_tests++;
      if (log_q[i].dn !== 3'b100 || log_q[i].up !== 3'b000) begin
        n_fail++; $display("FAIL repeat_value[%0d]: got up=%b dn=%b expected up=000 dn=100",
                           i, log_q[i].up, log_q[i].dn);
      end
    end
    idle_all();
  endtask

  task automatic test_conflicts();
    int k;
    bus.sel = 3'b001;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step(3);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL both_busy: got %b expected 1", bus.busy);
    end
    step(9);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(4);
    n_tests++;
    if (log_q.size() != 0) begin
      n_fail++; $display("FAIL both_no_tick: got %0d expected 0", log_q.size());
    end
    idle_all();

    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(5);
    bus.btn_down = 1'b1;
    step(15);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(4);
    n_tests++;
    if (log_q.size() != 1) begin
      n_fail++; $display("FAIL opposite_count: got %0d expected 1", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0].cyc - k != 1 || log_q[0].up !== 3'b001) begin
        n_fail++; $display("FAIL opposite_tick: got cycle %0d up=%b expected cycle 1 up=001",
                           log_q[0].cyc - k, log_q[0].up);
      end
    end
    idle_all();

    bus.sel = 3'b001;
    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(5);
    bus.sel = 3'b010;
    step(15);
    bus.btn_up = 1'b0;
    step(4);
    n_tests++;
    if (log_q.size() != 1) begin
      n_fail++; $display("FAIL selchg_count: got %0d expected 1", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0].cyc - k != 1 || log_q[0].up !== 3'b001) begin
        n_fail++; $display("FAIL selchg_tick: got cycle %0d up=%b expected cycle 1 up=001",
                           log_q[0].cyc - k, log_q[0].up);
      end
    end
    idle_all();
  endtask

  task automatic test_priority();
    int k;
    bus.sel = 3'b110;
    k = cyc + 1;
    bus.btn_up = 1'b1;
    step(3);
    bus.btn_up = 1'b0;
    step(4);
    n_tests++;
    if (log_q.size() != 1) begin
      n_fail++; $display("FAIL prio_count: got %0d expected 1", log_q.size());
    end else begin
      n_tests++;
      if (log_q[0].cyc - k != 1 || log_q[0].up !== 3'b010 || log_q[0].dn !== 3'b000) begin
        n_fail++; $display("FAIL prio_tick: got cycle %0d up=%b dn=%b expected cycle 1 up=010 dn=000",
                           log_q[0].cyc - k, log_q[0].up, log_q[0].dn);
      end
    end
    idle_all();

    bus.sel = 3'b000;
    bus.btn_up = 1'b1;
    step(3);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL nosel_busy_high: got %b expected 1", bus.busy);
    end
    bus.btn_up = 1'b0;
    step(2);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL nosel_busy_low: got %b expected 0", bus.busy);
    end
    n_tests++;
    if (log_q.size() != 0) begin
      n_fail++; $display("FAIL nosel_no_tick: got %0d expected 0", log_q.size());
    end
    idle_all();
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.sel      = 3'b000;
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_conflicts();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
